// File: rtl/vend_pkg.sv
// Shared definitions for the vending dispense scheduler: coin codes,
// coin-value decoding and the scheduler FSM state encoding.
package vend_pkg;

    // Coin codes as presented on each 2-bit coin lane
    localparam logic [1:0] COIN_NONE = 2'b00;
    localparam logic [1:0] COIN_5    = 2'b01;
    localparam logic [1:0] COIN_10   = 2'b10;
    localparam logic [1:0] COIN_BAD  = 2'b11;

    // Scheduler states; FAULT is terminal until reset
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SERVE = 2'd1,
        FAULT = 2'd2
    } vend_state_e;

    // Value of a coin code in credit units; none and invalid count as zero
    function automatic logic [1:0] coin_units(input logic [1:0] code);
        case (code)
            COIN_5:  return 2'd1;
            COIN_10: return 2'd2;
            default: return 2'd0;
        endcase
    endfunction

endpackage

// File: rtl/vend_rr_arbiter.sv
// Combinational round-robin picker: returns the first set request bit at or
// after the pointer, wrapping around the request vector.
module vend_rr_arbiter #(
    parameter int N     = 4,
    parameter int IDX_W = $clog2(N)
) (
    input  logic [N-1:0]     req_i,
    input  logic [IDX_W-1:0] ptr_i,
    output logic             gnt_valid_o,
    output logic [IDX_W-1:0] gnt_idx_o
);

    // Scan offsets from the far end so the closest request to the pointer wins last
    always_comb begin
        int idx;
        // NOTE: every combinational output gets a default first, so no path leaves it unassigned (no latch).
        gnt_valid_o = 1'b0;
        gnt_idx_o   = '0;
        idx         = 0;
        for (int i = N - 1; i >= 0; i--) begin
            idx = (int'(ptr_i) + i) % N;
            if (req_i[idx]) begin
                gnt_valid_o = 1'b1;
                gnt_idx_o   = IDX_W'(idx);
            end
        end
    end

endmodule

// File: rtl/vend_dispense_scheduler.sv
// Shares one dispenser among N_PORTS coin front-panels: per-port credit
// accumulation, round-robin selection of ports that reached PRICE, a
// valid/ready dispense handshake and a sticky timeout fault.
module vend_dispense_scheduler
    import vend_pkg::*;
#(
    parameter int N_PORTS  = 4,
    parameter int PRICE    = 3,
    parameter int CREDIT_W = 4,
    parameter int TIMEOUT  = 15,
    localparam int PORT_W  = $clog2(N_PORTS)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [2*N_PORTS-1:0]   coin_in,
    output logic                   disp_valid,
    input  logic                   disp_ready,
    output logic [PORT_W-1:0]      disp_port,
    output logic [CREDIT_W-1:0]    disp_change,
    output logic [N_PORTS-1:0]     vend_done,
    output logic [N_PORTS-1:0]     coin_rej,
    output logic                   fault
);

    localparam int                 TMR_W      = $clog2(TIMEOUT + 1);
    localparam logic [CREDIT_W:0]  CREDIT_MAX = {1'b0, {CREDIT_W{1'b1}}};
    localparam logic [CREDIT_W-1:0] PRICE_C   = CREDIT_W'(PRICE);
    localparam logic [TMR_W-1:0]   TMR_LAST   = TMR_W'(TIMEOUT - 1);
    localparam logic [PORT_W-1:0]  PORT_LAST  = PORT_W'(N_PORTS - 1);

    vend_state_e          state_q, state_d;
    logic [CREDIT_W-1:0]  credit_q [N_PORTS];
    logic [CREDIT_W-1:0]  credit_d [N_PORTS];
    logic [N_PORTS-1:0]   ready_q, ready_d;
    logic [N_PORTS-1:0]   done_q, done_d;
    logic [N_PORTS-1:0]   rej_q, rej_d;
    logic [PORT_W-1:0]    port_q, port_d;
    logic [PORT_W-1:0]    rr_q, rr_d;
    logic [CREDIT_W-1:0]  change_q, change_d;
    logic [TMR_W-1:0]     timer_q, timer_d;

    logic                 serving;
    logic                 handshake;
    logic                 arb_valid;
    logic [PORT_W-1:0]    arb_idx;

    assign serving   = (state_q == SERVE);
    assign handshake = serving && disp_ready;

    vend_rr_arbiter #(
        .N     (N_PORTS),
        .IDX_W (PORT_W)
    ) u_arb (
        .req_i       (ready_q),
        .ptr_i       (rr_q),
        .gnt_valid_o (arb_valid),
        .gnt_idx_o   (arb_idx)
    );

    // Per-port credit update: accept, reject, or clear on a completed vend
    always_comb begin
        logic [1:0]        code;
        logic [CREDIT_W:0] sum;
        code  = COIN_NONE;
        sum   = '0;
        rej_d = '0;
        for (int p = 0; p < N_PORTS; p++) begin
            credit_d[p] = credit_q[p];
            code        = coin_in[2*p +: 2];
            sum         = {1'b0, credit_q[p]} + {{(CREDIT_W-1){1'b0}}, coin_units(code)};
            if (code != COIN_NONE) begin
                if (code == COIN_BAD || sum > CREDIT_MAX ||
                    (serving && port_q == PORT_W'(p))) begin
                    rej_d[p] = 1'b1;
                end else begin
                    credit_d[p] = sum[CREDIT_W-1:0];
                end
            end
            if (handshake && port_q == PORT_W'(p)) begin
                credit_d[p] = '0;
            end
        end
    end

    // Price-reached flags lag credit by one edge; the port just vended is masked
    always_comb begin
        ready_d = '0;
        for (int p = 0; p < N_PORTS; p++) begin
            ready_d[p] = (credit_q[p] >= PRICE_C) &&
                         !(handshake && port_q == PORT_W'(p));
        end
    end

    // Grant capture, dispense timer, round-robin pointer and done pulse
    always_comb begin
        port_d   = port_q;
        change_d = change_q;
        timer_d  = timer_q;
        rr_d     = rr_q;
        done_d   = '0;
        case (state_q)
            IDLE: begin
                if (arb_valid) begin
                    port_d   = arb_idx;
                    change_d = credit_q[arb_idx] - PRICE_C;
                    timer_d  = '0;
                end
            end
            SERVE: begin
                if (handshake) begin
                    done_d = N_PORTS'(1) << port_q;
                    rr_d   = (port_q == PORT_LAST) ? '0 : port_q + 1'b1;
                end else if (timer_q != TMR_LAST) begin
                    timer_d = timer_q + 1'b1;
                end
            end
            default: ;
        endcase
    end

    // FSM next state
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (arb_valid) state_d = SERVE;
            SERVE: begin
                if (handshake)               state_d = IDLE;
                else if (timer_q == TMR_LAST) state_d = FAULT;
            end
            FAULT:   state_d = FAULT;
            default: state_d = IDLE;
        endcase
    end

    // FSM state register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Datapath registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            // NOTE: the credit array is a handful of flops, not a RAM, so it is reset with everything else.
            for (int p = 0; p < N_PORTS; p++) begin
                credit_q[p] <= '0;
            end
            ready_q  <= '0;
            done_q   <= '0;
            rej_q    <= '0;
            port_q   <= '0;
            rr_q     <= '0;
            change_q <= '0;
            timer_q  <= '0;
        end else begin
            // NOTE: sequential state uses non-blocking assignment so every flop samples pre-edge values.
            for (int p = 0; p < N_PORTS; p++) begin
                credit_q[p] <= credit_d[p];
            end
            ready_q  <= ready_d;
            done_q   <= done_d;
            rej_q    <= rej_d;
            port_q   <= port_d;
            rr_q     <= rr_d;
            change_q <= change_d;
            timer_q  <= timer_d;
        end
    end

    // FSM outputs: dispense request only while serving, fault while faulted
    always_comb begin
        disp_valid  = serving;
        disp_port   = serving ? port_q : '0;
        disp_change = serving ? change_q : '0;
        fault       = (state_q == FAULT);
        vend_done   = done_q;
        coin_rej    = rej_q;
    end

endmodule
